// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: handshake and register-control bundle between the bit-serial adder sequencer and its surroundings
// Parameter WIDTH: operand width; bitcnt is $clog2(WIDTH) bits wide (minimum 1).
// Signals (slave = sequencer view):
//   start  in   request an addition, sampled only while idle
//   sub    in   subtract select, present only when SERIAL_SUB_EN is defined
//   a_s    in   serial LSB-first bit of operand A (accumulator)
//   b_s    in   serial LSB-first bit of operand B
//   le     out  parallel load enable for both registers
//   she    out  shift enable for both registers
//   si     out  sum bit fed to the accumulator serial input
//   poute  out  accumulator parallel-output enable, high while the result is valid
//   busy   out  high during load and shift
//   done   out  one-cycle completion pulse
//   cout   out  final carry (no-borrow flag when subtracting), valid while poute=1
//   bitcnt out  bit index during shift
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic start;
`ifdef SERIAL_SUB_EN
    logic sub;
`endif
    logic a_s;
    logic b_s;
    logic le;
    logic she;
    logic si;
    logic poute;
    logic busy;
    logic done;
    logic cout;
    logic [CW-1:0] bitcnt;
    modport slave (
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        input  start, a_s, b_s,
        output le, she, si, poute, busy, done, cout, bitcnt
    );
    modport master (
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        output start, a_s, b_s,
        input  le, she, si, poute, busy, done, cout, bitcnt
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer for bit-serial addition of two WIDTH-bit operands held in external shift registers
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_add_ctrl_if.slave (start, a_s, b_s, le, she, si, poute, busy, done, cout, bitcnt)
// Optional feature macro SERIAL_SUB_EN: adds bus.sub; when set at start the operation computes A-B
// by inverting the B stream and seeding the carry with 1, so cout=1 means no borrow.
// Timing: start seen at edge 0 -> load cycle 1 -> shift cycles 2..WIDTH+1 -> done cycle WIDTH+2,
// poute/cout valid from the following idle cycle on.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_ctrl_if.slave     bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            poute_q;
    logic            cout_q;
    logic            sub_q;
    logic            b_eff;
    logic            last;

`ifdef SERIAL_SUB_EN
    assign b_eff = bus.b_s ^ sub_q;
`else
    assign b_eff = bus.b_s;
    assign sub_q = 1'b0;
`endif

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    // An unknown start evaluates false in the if, so it is treated as 0
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            poute_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) poute_q <= 1'b0;
                LOAD: begin
                    carry_q <= sub_q;
                    cnt_q   <= '0;
                end
                SHIFT: begin
                    carry_q <= (bus.a_s & b_eff) | (bus.a_s & carry_q) | (b_eff & carry_q);
                    cnt_q   <= last ? '0 : cnt_q + 1'b1;
                end
                FIN: begin
                    cout_q  <= carry_q;
                    poute_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_EN
    // Operation mode is captured with the accepted start and held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else if (state_q == IDLE && bus.start) sub_q <= bus.sub;
    end
`endif

    assign bus.le     = (state_q == LOAD);
    assign bus.she    = (state_q == SHIFT);
    assign bus.busy   = (state_q == LOAD) || (state_q == SHIFT);
    assign bus.done   = (state_q == FIN);
    assign bus.si     = (state_q == SHIFT) ? (bus.a_s ^ b_eff ^ carry_q) : 1'b0;
    assign bus.poute  = poute_q;
    assign bus.cout   = cout_q;
    assign bus.bitcnt = cnt_q;

    a_le_she_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus.le && bus.she));
    a_done_pulse:  assert property (@(posedge clk) disable iff (!rst_n) bus.done |=> !bus.done);
    a_busy_state:  assert property (@(posedge clk) disable iff (!rst_n)
                                    bus.busy == (state_q == LOAD || state_q == SHIFT));
    a_si_quiet:    assert property (@(posedge clk) disable iff (!rst_n) !bus.she |-> !bus.si);
    a_start_known: assert property (@(posedge clk) disable iff (!rst_n)
                                    (state_q == IDLE) |-> !$isunknown(bus.start));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench with behavioural shift registers and a cycle-level reference model
module tb_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic        sub_in = 1'b0;
    logic [7:0]  acc, breg;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_she = 0;
    int          n_done = 0;
    int          lat;

    int          phase = 0;
    logic [8:0]  msum = '0;
    logic        e_poute = 1'b0;
    logic        e_cout = 1'b0;
    logic        in_shift;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Operand registers: A accumulates the sum through its serial input, B just drains
    always_ff @(posedge clk) begin
        if (bus.le) begin
            acc  <= a_in;
            breg <= b_in;
        end else if (bus.she) begin
            acc  <= {bus.si, acc[7:1]};
            breg <= {1'b0, breg[7:1]};
        end
    end
    assign bus.a_s = acc[0];
    assign bus.b_s = breg[0];
`ifdef SERIAL_SUB_EN
    assign bus.sub = sub_in;
`endif

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: phase counts cycles since the accepted start; the full sum is precomputed arithmetically
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 0;
            e_poute <= 1'b0;
            e_cout  <= 1'b0;
        end else if (phase == 0) begin
            if (bus.start === 1'b1) begin
                phase   <= 1;
                e_poute <= 1'b0;
                msum    <= sub_in ? {1'b0, a_in} + {1'b0, ~b_in} + 9'd1 : {1'b0, a_in} + {1'b0, b_in};
            end
        end else if (phase == 10) begin
            phase   <= 0;
            e_poute <= 1'b1;
            e_cout  <= msum[8];
        end else begin
            phase <= phase + 1;
        end
    end

    assign in_shift = (phase >= 2) && (phase <= 9);

    always @(negedge clk) begin
        chk("le", bus.le, phase == 1);
        chk("she", bus.she, in_shift);
        chk("busy", bus.busy, phase >= 1 && phase <= 9);
        chk("done", bus.done, phase == 10);
        chk("si", bus.si, in_shift ? msum[phase-2] : 1'b0);
        chk("poute", bus.poute, e_poute);
        chk("cout", bus.cout, e_cout);
        if (in_shift) chk("bitcnt", bus.bitcnt, phase - 2);
        if (e_poute) chk("acc", acc, msum[7:0]);
        if (bus.she) n_she++;
        if (bus.done) n_done++;
    end

    task automatic wait_done(output int l);
        l = 1;
        while (bus.done !== 1'b1 && l < 20) begin
            @(posedge clk);
            #2;
            l++;
        end
        chk("done_seen", bus.done, 1'b1);
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s, output int l);
        a_in = a;
        b_in = b;
        sub_in = s;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        wait_done(l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_le", bus.le, 0);
        chk("rst_she", bus.she, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_poute", bus.poute, 0);
        chk("rst_bitcnt", bus.bitcnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        n_she = 0;
        op(8'hA4, 8'h5B, 1'b0, lat);
        chk("lat_a4", lat, 10);
        chk("sum_a4", acc, 8'hFF);
        chk("cout_a4", bus.cout, 1'b0);
        chk("poute_a4", bus.poute, 1'b1);
        chk("she_cycles", n_she, 8);

        op(8'hFF, 8'h01, 1'b0, lat);
        chk("sum_ff", acc, 8'h00);
        chk("cout_ff", bus.cout, 1'b1);

        // Extra start pulses in cycles 3 and 10 must be ignored; cycle 11 start is accepted
        n_done = 0;
        a_in = 8'h12;
        b_in = 8'h34;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            @(posedge clk);
            #2;
            if (c == 12) begin
                chk("reload_le", bus.le, 1'b1);
                chk("single_done", n_done, 1);
                bus.start = 1'b0;
            end else begin
                if (c == 11) chk("sum_12", acc, 8'h46);
                bus.start = (c == 3 || c == 10 || c == 11);
            end
        end
        wait_done(lat);
        chk("sum_12b", acc, 8'h46);

        // Reset in the fifth shift cycle
        a_in = 8'h55;
        b_in = 8'h0F;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_she", bus.she, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_she", bus.she, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_si", bus.si, 0);
        chk("mid_rst_bitcnt", bus.bitcnt, 0);
        chk("mid_rst_cout", bus.cout, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        op(8'h03, 8'h04, 1'b0, lat);
        chk("sum_07", acc, 8'h07);
        chk("cout_07", bus.cout, 1'b0);

`ifdef SERIAL_SUB_EN
        op(8'h10, 8'h01, 1'b1, lat);
        chk("sub_0f", acc, 8'h0F);
        chk("sub_cout1", bus.cout, 1'b1);
        op(8'h01, 8'h02, 1'b1, lat);
        chk("sub_ff", acc, 8'hFF);
        chk("sub_cout0", bus.cout, 1'b0);
        op(8'h20, 8'h22, 1'b0, lat);
        chk("add_after_sub", acc, 8'h42);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
